spine_link_adapter: RTL and testbench

Registered link stage between one router spine port (e.g. `spine14_*` of the 4-router group tile) and the external spine interconnect. The router's spine ports carry no back-pressure, so this block adds flow control on both sides:
- **Egress (router → spine):** flits go through a FIFO to a valid/ready spine link, and overflows are counted.
- **Ingress (spine → router):** spine flits are registered, and the 6-bit destination sideband the router expects is generated from the flit header.

One adapter is instantiated per spine port.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/noc_sync_fifo.sv | 62 ++++++
 rtl/spine_link_adapter.sv | 88 ++++++++
 tb/tb_spine_link_adapter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, header decode and FIFO operation codes.
package noc_pkg;

    localparam int unsigned FLIT_W   = 16;
    localparam int unsigned DEST_W   = 6;
    localparam int unsigned DEST_MSB = 15;
    localparam int unsigned DROP_W   = 16;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic logic [DEST_W-1:0] dest_of(input logic [FLIT_W-1:0] flit);
        return flit[DEST_MSB -: DEST_W];
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO with separate occupancy counter; a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter  int unsigned DWIDTH = 16,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_head,
    output logic              o_valid,
    output logic [CW-1:0]     o_count,
    output logic              o_full
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    fifo_op_e          w_op;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & (~w_full | w_pop);
    assign w_op   = fifo_op_e'({w_push, w_pop});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case (w_op)
                FIFO_PUSH: r_count <= r_count + CW'(1);
                FIFO_POP:  r_count <= r_count - CW'(1);
                default:   r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; the head is masked by o_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/spine_link_adapter.sv
// Link stage between a router spine port and the spine interconnect: egress
// FIFO with drop counting, and a registered ingress path with dest decode.
module spine_link_adapter
    import noc_pkg::*;
#(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DWIDTH-1:0]      rtr_out_data,
    input  logic                   rtr_out_valid,
    output logic [DWIDTH-1:0]      spine_tx_data,
    output logic [ADDR_W-1:0]      spine_tx_dest,
    output logic                   spine_tx_valid,
    input  logic                   spine_tx_ready,
    input  logic [DWIDTH-1:0]      spine_rx_data,
    input  logic                   spine_rx_valid,
    output logic                   spine_rx_ready,
    output logic [DWIDTH-1:0]      rtr_in_data,
    output logic                   rtr_in_valid,
    output logic [ADDR_W-1:0]      rtr_in_dest_addr,
    output logic [$clog2(DEPTH):0] egress_count,
    output logic                   egress_full,
    output logic [DROP_W-1:0]      drop_cnt
);

    logic [DWIDTH-1:0] w_head;
    logic              w_valid;
    logic              w_full;
    logic              w_drop;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [DWIDTH-1:0] r_rin_data;
    logic              r_rin_valid;
    logic              r_rx_ready;

    noc_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_egress_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (rtr_out_valid),
        .i_data  (rtr_out_data),
        .i_pop   (spine_tx_ready),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (egress_count),
        .o_full  (w_full)
    );

    // A flit is lost only when the FIFO is full and nothing leaves this cycle.
    assign w_drop = rtr_out_valid & w_full & ~(w_valid & spine_tx_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt  <= '0;
            r_rin_data  <= '0;
            r_rin_valid <= 1'b0;
            r_rx_ready  <= 1'b0;
        end else begin
            r_rx_ready  <= 1'b1;
            r_rin_valid <= spine_rx_valid & r_rx_ready;
            if (spine_rx_valid & r_rx_ready) r_rin_data <= spine_rx_data;
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    generate
        if (DWIDTH == FLIT_W && ADDR_W == DEST_W) begin : g_pkg_dest
            assign spine_tx_dest    = dest_of(w_head);
            assign rtr_in_dest_addr = dest_of(r_rin_data);
        end else begin : g_generic_dest
            assign spine_tx_dest    = w_head[DWIDTH-1 -: ADDR_W];
            assign rtr_in_dest_addr = r_rin_data[DWIDTH-1 -: ADDR_W];
        end
    endgenerate

    assign spine_tx_data  = w_head;
    assign spine_tx_valid = w_valid;
    assign egress_full    = w_full;
    assign drop_cnt       = r_drop_cnt;
    assign rtr_in_data    = r_rin_data;
    assign rtr_in_valid   = r_rin_valid;
    assign spine_rx_ready = r_rx_ready;

endmodule

// File: tb/tb_spine_link_adapter.sv
// Self-checking bench for spine_link_adapter: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_spine_link_adapter;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rtr_out_data;
    logic        rtr_out_valid;
    logic [15:0] spine_tx_data;
    logic [5:0]  spine_tx_dest;
    logic        spine_tx_valid;
    logic        spine_tx_ready;
    logic [15:0] spine_rx_data;
    logic        spine_rx_valid;
    logic        spine_rx_ready;
    logic [15:0] rtr_in_data;
    logic        rtr_in_valid;
    logic [5:0]  rtr_in_dest_addr;
    logic [3:0]  egress_count;
    logic        egress_full;
    logic [15:0] drop_cnt;

    spine_link_adapter #(
        .DWIDTH (16),
        .DEPTH  (DEPTH),
        .ADDR_W (6)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rtr_out_data     (rtr_out_data),
        .rtr_out_valid    (rtr_out_valid),
        .spine_tx_data    (spine_tx_data),
        .spine_tx_dest    (spine_tx_dest),
        .spine_tx_valid   (spine_tx_valid),
        .spine_tx_ready   (spine_tx_ready),
        .spine_rx_data    (spine_rx_data),
        .spine_rx_valid   (spine_rx_valid),
        .spine_rx_ready   (spine_rx_ready),
        .rtr_in_data      (rtr_in_data),
        .rtr_in_valid     (rtr_in_valid),
        .rtr_in_dest_addr (rtr_in_dest_addr),
        .egress_count     (egress_count),
        .egress_full      (egress_full),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] q[$];
    int          m_drop;
    bit          m_riv;
    logic [15:0] m_rid;
    bit          m_rxr;

    typedef struct {
        bit          ov;
        logic [15:0] od;
        bit          rdy;
        bit          rv;
        logic [15:0] rd;
        bit          e_tv;
        logic [15:0] e_td;
        logic [5:0]  e_dest;
        logic [3:0]  e_cnt;
        bit          e_riv;
        logic [15:0] e_rid;
        logic [5:0]  e_rdest;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(egress_count), 32'(q.size()));
        chk("tx_valid", 32'(spine_tx_valid), 32'(q.size() != 0));
        chk("full", 32'(egress_full), 32'(q.size() == DEPTH));
        if (q.size() != 0) begin
            chk("tx_data", 32'(spine_tx_data), 32'(q[0]));
            chk("tx_dest", 32'(spine_tx_dest), 32'(q[0]) / 32'd1024);
        end
        chk("drop", 32'(drop_cnt), 32'(m_drop));
        chk("rin_valid", 32'(rtr_in_valid), 32'(m_riv));
        chk("rin_data", 32'(rtr_in_data), 32'(m_rid));
        chk("rin_dest", 32'(rtr_in_dest_addr), 32'(m_rid) / 32'd1024);
        chk("rx_ready", 32'(spine_rx_ready), 32'(m_rxr));
    endtask

    task automatic step(input bit ov, input logic [15:0] od, input bit rdy,
                        input bit rv, input logic [15:0] rd);
        bit pop;
        rtr_out_valid  = ov;
        rtr_out_data   = od;
        spine_tx_ready = rdy;
        spine_rx_valid = rv;
        spine_rx_data  = rd;
        pop = rdy && (q.size() != 0);
        if (ov && q.size() == DEPTH && !pop && m_drop < 65535) m_drop++;
        if (pop) void'(q.pop_front());
        if (ov && q.size() < DEPTH) q.push_back(od);
        m_riv = rv && m_rxr;
        if (m_riv) m_rid = rd;
        @(posedge clk);
        #1;
        m_rxr = 1'b1;
        check_model();
    endtask

    task automatic do_reset();
        rtr_out_valid  = 1'b0;
        spine_tx_ready = 1'b0;
        spine_rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #2;
        chk("rst_tx_valid", 32'(spine_tx_valid), 32'd0);
        chk("rst_count", 32'(egress_count), 32'd0);
        chk("rst_full", 32'(egress_full), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_rin_valid", 32'(rtr_in_valid), 32'd0);
        chk("rst_rin_data", 32'(rtr_in_data), 32'd0);
        chk("rst_rx_ready", 32'(spine_rx_ready), 32'd0);
        q.delete();
        m_drop = 0;
        m_riv  = 1'b0;
        m_rid  = '0;
        m_rxr  = 1'b0;
        @(posedge clk);
        #1;
        check_model();
        reset = 1'b0;
        #2;
        chk("rx_ready_before_edge", 32'(spine_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        m_rxr = 1'b1;
        chk("rx_ready_after_release", 32'(spine_rx_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rtr_out_data  = '0;
        spine_rx_data = '0;
        do_reset();

        // Ordering with stall plus one ingress flit
        tbl[0] = '{1'b1, 16'h0401, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0401, 6'd1, 4'd1, 1'b0, 16'h0000, 6'h00};
        tbl[1] = '{1'b1, 16'h0802, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0401, 6'd1, 4'd2, 1'b0, 16'h0000, 6'h00};
        tbl[2] = '{1'b1, 16'h0C03, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0401, 6'd1, 4'd3, 1'b0, 16'h0000, 6'h00};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFC55, 1'b1, 16'h0401, 6'd1, 4'd3, 1'b1, 16'hFC55, 6'h3F};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0401, 6'd1, 4'd3, 1'b0, 16'hFC55, 6'h3F};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0802, 6'd2, 4'd2, 1'b0, 16'hFC55, 6'h3F};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0C03, 6'd3, 4'd1, 1'b0, 16'hFC55, 6'h3F};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 6'd0, 4'd0, 1'b0, 16'hFC55, 6'h3F};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].ov, tbl[i].od, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
            chk("tbl_tx_valid", 32'(spine_tx_valid), 32'(tbl[i].e_tv));
            if (tbl[i].e_tv) begin
                chk("tbl_tx_data", 32'(spine_tx_data), 32'(tbl[i].e_td));
                chk("tbl_tx_dest", 32'(spine_tx_dest), 32'(tbl[i].e_dest));
            end
            chk("tbl_count", 32'(egress_count), 32'(tbl[i].e_cnt));
            chk("tbl_rin_valid", 32'(rtr_in_valid), 32'(tbl[i].e_riv));
            chk("tbl_rin_data", 32'(rtr_in_data), 32'(tbl[i].e_rid));
            chk("tbl_rin_dest", 32'(rtr_in_dest_addr), 32'(tbl[i].e_rdest));
        end

        // Overflow: 10 pushes into an 8-deep stalled FIFO
        for (int i = 0; i < 10; i++) step(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0, 16'h0);
        chk("ovf_full", 32'(egress_full), 32'd1);
        chk("ovf_count", 32'(egress_count), 32'd8);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", 32'(spine_tx_data), 32'(16'hA000 + i));
            step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        end
        chk("ovf_empty", 32'(spine_tx_valid), 32'd0);

        // Full + push + pop in the same cycle
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'hB000 + i), 1'b0, 1'b0, 16'h0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0);
        chk("fpp_count", 32'(egress_count), 32'd8);
        chk("fpp_full", 32'(egress_full), 32'd1);
        chk("fpp_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("fpp_drain", 32'(spine_tx_data), (i < 7) ? 32'(16'hB001 + i) : 32'h0000BEEF);
            step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        end

        // Reset with three flits queued and a non-zero drop count
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hE000 + i), 1'b0, 1'b1, 16'(16'h5A00 + i));
        do_reset();

        // Pointer wrap: 3*DEPTH flits streamed through
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'b1, 16'(16'hC000 + i), 1'b1, 1'b0, 16'h0);
            chk("wrap_head", 32'(spine_tx_data), 32'(16'hC000 + i));
            chk("wrap_count", 32'(egress_count), 32'd1);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        chk("wrap_empty", 32'(egress_count), 32'd0);

        // Randomized traffic, alternating light and heavy back-pressure
        for (int i = 0; i < 2000; i++) begin
            bit hi_rdy;
            hi_rdy = ((i / 200) % 2) == 1;
            step($urandom_range(0, 3) != 0, 16'($urandom),
                 hi_rdy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1) == 1, 16'($urandom));
        end

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'hD000 + i), 1'b0, 1'b0, 16'h0);
        rtr_out_valid  = 1'b1;
        rtr_out_data   = 16'h7777;
        spine_tx_ready = 1'b0;
        spine_rx_valid = 1'b0;
        repeat (65530) @(posedge clk);
        #1;
        m_drop = 65530;
        chk("sat_bulk", 32'(drop_cnt), 32'd65530);
        for (int i = 0; i < 8; i++) step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
        chk("sat_hold", 32'(drop_cnt), 32'h0000FFFF);
        chk("sat_head", 32'(spine_tx_data), 32'h0000D000);
        chk("sat_count", 32'(egress_count), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
